key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable synchronized samples needed to accept a key change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, the number of held-pressed cycles after which a long press is flagged; legal range 2..2^26-1.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port key_raw, input, 4 bits: raw board keys, active-low (0 = pressed), asynchronous to clk.
REQ-006 SHALL have port key_clean, output, 4 bits: debounced level, active-low; this is what the control FSM's key input receives.
REQ-007 SHALL have port key_press, output, 4 bits: one-cycle pulse per accepted press (1 to 0).
REQ-008 SHALL have port key_release, output, 4 bits: one-cycle pulse per accepted release (0 to 1).
REQ-009 SHALL have port key_long, output, 4 bits: one-cycle pulse when a press has been held LONG_CYCLES cycles.

Function
REQ-010 SHALL pass each key_raw bit through a two-flop synchronizer before any other logic uses it.
REQ-011 SHALL run an independent per-channel FSM with states UP, CNT_DN, DOWN, CNT_UP.
- UP: key_clean=1.
- DOWN: key_clean=0.
- CNT_DN and CNT_UP hold the previous level.
REQ-012 In UP, a synchronized 0 SHALL go to CNT_DN with the counter at 1; otherwise the FSM stays in UP with the counter at 0.
REQ-013 In CNT_DN, a synchronized 1 SHALL return the FSM to UP and clear the counter.
- A synchronized 0 increments the counter.
- When the counter equals DEBOUNCE_CYCLES-1 and the sample is still 0, the FSM goes to DOWN, clears the counter, and asserts key_press for that channel for exactly the next cycle.
REQ-014 CNT_UP SHALL mirror CNT_DN with the polarity inverted, going to UP and pulsing key_release.
REQ-015 Total latency from a key_raw edge held stable to the key_clean change and the pulse SHALL be DEBOUNCE_CYCLES+2 clk cycles.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on key_clean and no pulse.
REQ-017 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses on the corresponding bits.
REQ-018 key_press and key_release SHALL never be asserted in the same cycle on the same channel, and SHALL never be asserted two cycles in a row on the same channel.
REQ-019 The debounce counter SHALL be 24 bits wide and SHALL never wrap, because it is cleared on every state exit.

Reset
REQ-020 While rst_n=0, all channels SHALL be in UP with counters at 0 and synchronizer flops at 1.
- Outputs during reset: key_clean=4'b1111, key_press=0, key_release=0, key_long=0.
REQ-021 Reset asserted mid-count or mid-hold SHALL abort the count without emitting any pulse.
- If the key is still held when reset is released, the normal debounce interval SHALL be required before key_press asserts.

Configuration
REQ-022 The macro KEY_DEBOUNCE_LONGPRESS_EN SHALL control long-press detection.
REQ-023 With KEY_DEBOUNCE_LONGPRESS_EN defined:
- Each channel in DOWN SHALL run a 26-bit hold counter, cleared on entry to DOWN.
- When the hold counter reaches LONG_CYCLES-1, key_long SHALL pulse once for the next cycle, and the counter SHALL saturate.
- Only one key_long pulse SHALL occur per press, and none after release.
REQ-024 With KEY_DEBOUNCE_LONGPRESS_EN undefined, key_long SHALL be constant 0 and no hold counter SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-025 The bench SHALL cover these scenarios with DEBOUNCE_CYCLES=4 and LONG_CYCLES=16:
- key_raw[0] 1 to 0, held 10 cycles -> key_clean[0]=0 and a key_press[0] pulse exactly 6 cycles after the edge; no other bit changes.
- key_raw[1] low for 3 cycles, then high -> key_clean stays 4'b1111, with zero pulses on any output.
- Bouncing 0/1/0/1 every cycle for 8 cycles, then stable 0 -> exactly one key_press[2], 6 cycles after the final edge.
- key_raw[3:0] all go low on the same cycle -> key_press=4'b1111 for one cycle; on release, key_release=4'b1111 for one cycle.
- Hold key_raw[0] low for 40 cycles with the macro defined -> exactly one key_long[0], 16 cycles after key_press[0]; with the macro undefined, key_long stays 0.
- rst_n pulsed low 2 cycles after a key_raw[0] press -> no pulse; key_press[0] occurs 6 cycles after rst_n deasserts.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync + per-key debounce FSM, press/release pulses.
// Long-press detection is built only when KEY_DEBOUNCE_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_raw,
    output logic [3:0] key_clean,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215) begin : g_bad_db
        $error("key_debounce: DEBOUNCE_CYCLES out of range");
    end

    if (LONG_CYCLES < 2 || LONG_CYCLES > 67108863) begin : g_bad_long
        $error("key_debounce: LONG_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        UP     = 2'd0,
        CNT_DN = 2'd1,
        DOWN   = 2'd2,
        CNT_UP = 2'd3
    } state_t;

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    state_t      state_q [4];
    state_t      state_d [4];
    logic [23:0] cnt_q   [4];
    logic [23:0] cnt_d   [4];
    logic [3:0]  press_q;
    logic [3:0]  press_d;
    logic [3:0]  release_q;
    logic [3:0]  release_d;

    // two-flop synchronizer, resets high to match released keys
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // per-channel state, debounce counter and registered edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= UP;
                cnt_q[i]   <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // next state: a level is accepted after DEBOUNCE_CYCLES equal samples
    always_comb begin
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            unique case (state_q[i])
                UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = CNT_DN;
                        cnt_d[i]   = 24'd1;
                    end
                end
                CNT_DN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = UP;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = DOWN;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 24'd1;
                    end
                end
                DOWN: begin
                    if (sync2_q[i]) begin
                        state_d[i] = CNT_UP;
                        cnt_d[i]   = 24'd1;
                    end
                end
                CNT_UP: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DOWN;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]   = UP;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 24'd1;
                    end
                end
                default: begin
                    state_d[i] = UP;
                end
            endcase
        end
    end

    // counting states keep the previously accepted level
    always_comb begin
        key_clean = '1;
        for (int i = 0; i < 4; i++) begin
            key_clean[i] = !(state_q[i] == DOWN || state_q[i] == CNT_UP);
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN

    localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);

    logic [25:0] hold_q [4];
    logic [3:0]  long_q;

    // hold timer runs while the press is accepted; saturates past the fire point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            long_q <= '0;
            for (int i = 0; i < 4; i++) begin
                if (state_q[i] == CNT_DN && state_d[i] == DOWN) begin
                    hold_q[i] <= '0;
                end else if (state_q[i] == DOWN || state_q[i] == CNT_UP) begin
                    if (hold_q[i] == LONG_LAST) begin
                        long_q[i] <= 1'b1;
                        hold_q[i] <= hold_q[i] + 26'd1;
                    end else if (hold_q[i] < LONG_LAST) begin
                        hold_q[i] <= hold_q[i] + 26'd1;
                    end
                end
            end
        end
    end

    assign key_long = long_q;

`else

    assign key_long = '0;

`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: random + directed stimulus against a run-length model.
// Expected key_long depends on KEY_DEBOUNCE_LONGPRESS_EN.
module tb_key_debounce;

    localparam int DB = 4;
    localparam int LG = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_raw;
    logic [3:0] key_clean;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_raw(key_raw),
        .key_clean(key_clean),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    logic [3:0] m_d1, m_d2, m_acc, m_prs, m_rel, m_lng;
    int m_run  [4];
    int m_held [4];
    bit m_fired[4];

    int n_prs[4], n_rel[4], n_lng[4];
    int t_prs[4], t_lng[4];
    int n_all_prs, n_all_rel;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_d1  = '1;
        m_d2  = '1;
        m_acc = '1;
        m_prs = '0;
        m_rel = '0;
        m_lng = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]   = 0;
            m_held[i]  = 0;
            m_fired[i] = 1'b1;
        end
    endfunction

    function automatic void clr_stats();
        for (int i = 0; i < 4; i++) begin
            n_prs[i] = 0;
            n_rel[i] = 0;
            n_lng[i] = 0;
            t_prs[i] = -1;
            t_lng[i] = -1;
        end
        n_all_prs = 0;
        n_all_rel = 0;
    endfunction

    // accepted level flips once DB samples in a row disagree with it
    function automatic void m_edge();
        logic [3:0] samp;
        samp  = m_d2;
        m_d2  = m_d1;
        m_d1  = key_raw;
        m_prs = '0;
        m_rel = '0;
        m_lng = '0;
        for (int i = 0; i < 4; i++) begin
            if (!m_acc[i] && !m_fired[i]) begin
                m_held[i]++;
                if (m_held[i] == LG) begin
                    m_lng[i]   = 1'b1;
                    m_fired[i] = 1'b1;
                end
            end
            if (samp[i] == m_acc[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_run[i] = 0;
                    m_acc[i] = samp[i];
                    if (samp[i]) begin
                        m_rel[i] = 1'b1;
                    end else begin
                        m_prs[i]   = 1'b1;
                        m_held[i]  = 0;
                        m_fired[i] = 1'b0;
                    end
                end
            end
        end
    endfunction

    task automatic tick(input logic [3:0] raw);
        logic [3:0] exp_long;
        key_raw = raw;
        @(posedge clk);
        cyc++;
        if (rst_n) m_edge();
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        exp_long = m_lng;
`else
        exp_long = 4'b0000;
`endif
        @(negedge clk);
        chk("clean", 32'(key_clean), 32'(m_acc));
        chk("press", 32'(key_press), 32'(m_prs));
        chk("release", 32'(key_release), 32'(m_rel));
        chk("long", 32'(key_long), 32'(exp_long));
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) begin
                n_prs[i]++;
                t_prs[i] = cyc;
            end
            if (key_release[i]) n_rel[i]++;
            if (key_long[i]) begin
                n_lng[i]++;
                t_lng[i] = cyc;
            end
        end
        if (key_press == 4'b1111) n_all_prs++;
        if (key_release == 4'b1111) n_all_rel++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(4'b1111);
    endtask

    initial begin
        int e;
        int dly[2];
        int left[4];
        logic [3:0] cur;

        rst_n   = 1'b0;
        key_raw = '1;
        m_reset();
        clr_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_clean", 32'(key_clean), 32'hf);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        chk("rst_long", 32'(key_long), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // single press on key 0
        clr_stats();
        e = cyc;
        for (int k = 0; k < 10; k++) tick(4'b1110);
        chk("s1_npress", 32'(n_prs[0]), 32'd1);
        chk("s1_lat", 32'(t_prs[0] - e), 32'd6);
        chk("s1_clean", 32'(key_clean), 32'b1110);
        chk("s1_others", 32'(n_prs[1] + n_prs[2] + n_prs[3] + n_rel[0]), 32'd0);
        idle(10);
        chk("s1_nrel", 32'(n_rel[0]), 32'd1);

        // short glitch on key 1
        clr_stats();
        for (int k = 0; k < 3; k++) tick(4'b1101);
        idle(10);
        chk("s2_pulses", 32'(n_prs[1] + n_rel[1] + n_prs[0] + n_prs[2]), 32'd0);
        chk("s2_clean", 32'(key_clean), 32'hf);

        // bouncing key 2 then stable low
        clr_stats();
        for (int k = 0; k < 8; k++) tick((k % 2 == 0) ? 4'b1011 : 4'b1111);
        e = cyc;
        for (int k = 0; k < 12; k++) tick(4'b1011);
        chk("s3_npress", 32'(n_prs[2]), 32'd1);
        chk("s3_lat", 32'(t_prs[2] - e), 32'd6);
        idle(10);

        // all keys together
        clr_stats();
        for (int k = 0; k < 10; k++) tick(4'b0000);
        chk("s4_allpress", 32'(n_all_prs), 32'd1);
        idle(10);
        chk("s4_allrel", 32'(n_all_rel), 32'd1);

        // long hold on key 0
        clr_stats();
        for (int k = 0; k < 40; k++) tick(4'b1110);
        idle(10);
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        chk("s5_nlong", 32'(n_lng[0]), 32'd1);
        chk("s5_lat", 32'(t_lng[0] - t_prs[0]), 32'd16);
`else
        chk("s5_nlong", 32'(n_lng[0]), 32'd0);
`endif
        chk("s5_npress", 32'(n_prs[0]), 32'd1);

        // reset in the middle of a debounce count
        dly[0] = 2;
        dly[1] = 5;
        for (int j = 0; j < 2; j++) begin
            clr_stats();
            for (int k = 0; k < dly[j]; k++) tick(4'b1110);
            rst_n = 1'b0;
            m_reset();
            tick(4'b1110);
            tick(4'b1110);
            chk("s6_abort", 32'(n_prs[0]), 32'd0);
            rst_n = 1'b1;
            e = cyc;
            for (int k = 0; k < 10; k++) tick(4'b1110);
            chk("s6_npress", 32'(n_prs[0]), 32'd1);
            chk("s6_lat", 32'(t_prs[0] - e), 32'd6);
            idle(10);
        end

        // random bouncing with occasional resets
        cur = '1;
        for (int i = 0; i < 4; i++) left[i] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (left[i] == 0) begin
                    cur[i] = 1'($urandom_range(1, 0));
                    if ($urandom_range(1, 0) == 0) left[i] = $urandom_range(3, 1);
                    else left[i] = $urandom_range(30, 4);
                end
                left[i]--;
            end
            if (rst_n && $urandom_range(599, 0) == 0) begin
                rst_n = 1'b0;
                m_reset();
            end else if (!rst_n) begin
                rst_n = 1'b1;
            end
            tick(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
